// File: rtl/progmem_arbiter.sv
// progmem_arbiter: shares one synchronous-read program memory among N_CORES fetch stages.
// Round-robin by default; define PROGMEM_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef INST_W
`define INST_W 32
`endif

module progmem_arbiter #(
  parameter int unsigned N_CORES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CORES-1:0]              req,
  input  logic [N_CORES*`INST_ADDR_W-1:0] req_addr,
  input  logic [N_CORES-1:0]              cancel,
  output logic [N_CORES-1:0]              rsp_valid,
  output logic [`INST_W-1:0]              rsp_data,
  output logic [N_CORES-1:0]              stall,
  output logic                            mem_en,
  output logic [`INST_ADDR_W-1:0]         mem_addr,
  input  logic [`INST_W-1:0]              mem_data
);

  localparam int unsigned IDW = $clog2(N_CORES);
  localparam int unsigned AW  = `INST_ADDR_W;

  logic                 inflight_v_q, inflight_v_d;
  logic [IDW-1:0]       inflight_id_q, inflight_id_d;
  logic [N_CORES-1:0]   inflight_mask;
  logic [N_CORES-1:0]   eligible;
  logic                 grant_v;
  logic [IDW-1:0]       grant_id;
  logic [AW-1:0]        addr_arr [N_CORES];

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    assign addr_arr[i]      = req_addr[i*AW +: AW];
    assign inflight_mask[i] = inflight_v_q && (inflight_id_q == IDW'(i));
    // Reset also swallows the response of an access caught in flight.
    assign rsp_valid[i]     = inflight_mask[i] && !cancel[i] && !rst;
  end

  // No grant while reset is asserted.
  assign eligible = req & ~cancel & ~inflight_mask & {N_CORES{~rst}};
  assign stall    = req & ~rsp_valid;
  assign rsp_data = mem_data;
  assign mem_en   = grant_v;
  assign mem_addr = grant_v ? addr_arr[grant_id] : '0;

`ifdef PROGMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (!grant_v && eligible[IDW'(i)]) begin
        grant_v  = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int unsigned off = 0; off < N_CORES; off++) begin
      idx = IDW'((32'(rr_ptr_q) + off) % N_CORES);
      if (!grant_v && eligible[idx]) begin
        grant_v  = 1'b1;
        grant_id = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_v) begin
      rr_ptr_d = (grant_id == IDW'(N_CORES - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_comb begin
    inflight_v_d  = grant_v;
    inflight_id_d = grant_v ? grant_id : inflight_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
    end
  end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Directed scoreboard bench for progmem_arbiter (default round-robin build, N_CORES=4).
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef INST_W
`define INST_W 32
`endif

module tb_progmem_arbiter;

  localparam int N  = 4;
  localparam int AW = `INST_ADDR_W;
  localparam int DW = `INST_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, cancel, rsp_valid, stall;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   rsp_data, mem_data;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;

  typedef struct {
    bit            v;
    int            core;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr [N];
  logic [AW-1:0] last_addr;
  int            total = 0;
  int            bad   = 0;

  progmem_arbiter #(.N_CORES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .cancel   (cancel),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .stall    (stall),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance scoreboard.
  // g = expected granted core this cycle, -1 for no grant.
  task automatic step(input logic r_st, input logic [N-1:0] r, input logic [N-1:0] c, input int g);
    exp_t e, n;
    logic [N-1:0] ev;
    @(negedge clk);
    rst    = r_st;
    req    = r;
    cancel = c;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    mem_data = memf(last_addr);
    #2;
    ev = '0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      if (e.v && !c[e.core] && !r_st) ev[e.core] = 1'b1;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev != '0) chk("rsp_data", 64'(rsp_data), 64'(e.data));
    chk("stall", 64'(stall), 64'(r & ~ev));
    chk("mem_en", 64'(mem_en), 64'(g >= 0));
    chk("mem_addr", 64'(mem_addr), (g >= 0) ? 64'(addr[g]) : 64'd0);
    last_addr = mem_addr;
    n.v    = (g >= 0);
    n.core = (g >= 0) ? g : 0;
    n.data = (g >= 0) ? memf(addr[g]) : '0;
    sb.push_back(n);
  endtask

  initial begin
    exp_t init_e;
    rst       = 1'b1;
    req       = '0;
    cancel    = '0;
    req_addr  = '0;
    mem_data  = '0;
    last_addr = '0;
    for (int i = 0; i < N; i++) addr[i] = AW'(16'h0100 + i * 16'h0111);
    init_e.v    = 1'b0;
    init_e.core = 0;
    init_e.data = '0;
    sb.push_back(init_e);

    // Reset, then idle: nothing valid, nothing enabled.
    step(1'b1, 4'b0000, 4'b0000, -1);
    step(1'b1, 4'b0000, 4'b0000, -1);
    step(1'b0, 4'b0000, 4'b0000, -1);

    // Single requester: grant every other cycle, 0xDEADBEEF back.
    addr[0] = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0001, 4'b0000, 0);
      step(1'b0, 4'b0001, 4'b0000, -1);
    end
    step(1'b0, 4'b0000, 4'b0000, -1);

    // All four requesting after reset: 0,1,2,3,0,1,2,3.
    step(1'b1, 4'b0000, 4'b0000, -1);
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1111, 4'b0000, k % 4);
    step(1'b0, 4'b0000, 4'b0000, -1);

    // Wrap: pointer to 3 via a grant to core 2, then 3,0,3.
    step(1'b0, 4'b0100, 4'b0000, 2);
    step(1'b0, 4'b1001, 4'b0000, 3);
    step(1'b0, 4'b1001, 4'b0000, 0);
    step(1'b0, 4'b1001, 4'b0000, 3);
    step(1'b0, 4'b0000, 4'b0000, -1);

    // Cancel in response cycle, then regrant with a new address.
    step(1'b0, 4'b0100, 4'b0000, 2);
    addr[2] = 16'h0ABC;
    step(1'b0, 4'b0100, 4'b0100, -1);
    step(1'b0, 4'b0100, 4'b0000, 2);
    step(1'b0, 4'b0000, 4'b0000, -1);

    // Cancel in issue cycle with pointer at 1.
    step(1'b0, 4'b0001, 4'b0000, 0);
    step(1'b0, 4'b0000, 4'b0000, -1);
    step(1'b0, 4'b0110, 4'b0010, 2);
    step(1'b0, 4'b0110, 4'b0000, 1);
    step(1'b0, 4'b0000, 4'b0000, -1);

    // Reset mid-flight: response dropped, pointer back to 0.
    step(1'b0, 4'b0010, 4'b0000, 1);
    step(1'b1, 4'b0010, 4'b0000, -1);
    step(1'b0, 4'b1010, 4'b0000, 1);
    step(1'b0, 4'b1010, 4'b0000, 3);
    step(1'b0, 4'b0000, 4'b0000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Shares one single-port, synchronous-read program memory between `N_CORES` fetch stages. Each cycle, the block grants at most one pending fetch request, round-robin, and drives that core's address to memory. One cycle later it routes the memory's read data back to the granted core with a valid strobe. It sits between the per-core fetch stages and the shared instruction memory, and produces the fetch stall condition for each core.

## Interface
Parameters:
- `N_CORES`, default 4: number of requesting cores; ≥2.
- Widths `` `INST_ADDR_W `` and `` `INST_W `` come from `defines.vh`.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N_CORES: fetch request per core; held until `rsp_valid` for that core, or until cancelled.
- `req_addr`  in  N_CORES*`INST_ADDR_W`: per-core fetch address; core i occupies slice i; must be stable while `req[i]` is high.
- `cancel`  in  N_CORES: per-core flush/jump; discards that core's pending or in-flight fetch.
- `rsp_valid`  out  N_CORES: one-cycle strobe; `rsp_data` belongs to core i.
- `rsp_data`  out  `INST_W`: instruction word, broadcast to all cores.
- `stall`  out  N_CORES: core i must not advance its PC this cycle.
- `mem_en`  out  1: memory read enable.
- `mem_addr`  out  `INST_ADDR_W`: memory read address.
- `mem_data`  in  `INST_W`: memory read data, valid the cycle after `mem_en`.

## Operation
- Eligible set: `req & ~cancel & ~inflight_mask`.
  - `inflight_mask` is one-hot of `inflight_id` when `inflight_v` = 1, else 0.
  - A core is never granted twice in consecutive cycles.
- Arbitration is combinational and round-robin.
  - The search starts at pointer `rr_ptr` and wraps from N_CORES-1 to 0.
  - The first eligible core wins.
- When there is a grant g:
  - `mem_en` = 1 and `mem_addr` = `req_addr[g]`.
  - Registered: `inflight_v` ← 1, `inflight_id` ← g, `rr_ptr` ← (g+1) mod N_CORES.
- With no grant, `mem_en` = 0, `mem_addr` = 0, `inflight_v` ← 0, and `rr_ptr` is unchanged.
- Response: `rsp_valid[i]` = `inflight_v` && `inflight_id`==i && !`cancel[i]`.
- `rsp_data` = `mem_data`, passed through combinationally.
- `stall[i]` = `req[i]` && !`rsp_valid[i]`.
- Cancel:
  - `cancel[i]` in the issue cycle blocks the grant to core i.
  - `cancel[i]` in the response cycle suppresses `rsp_valid[i]`; the memory read is wasted and nothing is retried.
- After `rsp_valid[i]`, the core may keep `req[i]` high with a new address in that same cycle. It becomes eligible again the following cycle.

## Timing
- Reset values:
  - `inflight_v` = 0, `inflight_id` = 0, `rr_ptr` = 0.
  - `rsp_valid` = 0 and `mem_en` = 0 in the cycle after `rst` is sampled, assuming `req` = 0.
- Latency: grant in cycle t, then `rsp_valid` in cycle t+1. Minimum request-to-data is 1 cycle.
- Throughput:
  - Aggregate: 1 fetch/cycle when ≥2 cores are requesting.
  - Single core alone: 1 fetch per 2 cycles.
- Fairness: a continuously requesting core waits at most N_CORES cycles for a grant.
- Reset mid-operation: `rst` in cycle t+1 with an access in flight clears `inflight_v`. No `rsp_valid` is produced during or after reset for the discarded access, and no grant is issued while `rst` = 1.
- Simultaneous response to core i and a new grant to core j≠i in the same cycle is normal pipelined operation.
- `rr_ptr` wrap-around: a grant to core N_CORES-1 sets `rr_ptr` to 0.

## Configuration
- `PROGMEM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest eligible index wins, `rr_ptr` is not implemented, and the fairness bound no longer applies.
  - Undefined (default): round-robin as specified above.
  - Latency, cancel, and in-flight exclusion rules are identical in both modes.

## Test plan
- Single requester: only `req[0]`=1, addr 0x10, `mem_data` = 0xDEADBEEF.
  - Expect `mem_en` in cycles 1, 3, 5.
  - Expect `rsp_valid[0]` in cycles 2, 4, 6 carrying 0xDEADBEEF.
  - Expect `stall[0]` = 1 in the odd cycles.
- All four cores requesting continuously: grants 0,1,2,3,0,… one per cycle, with `mem_addr` matching each core's slice. With the macro defined, grants alternate 0,1,0,1,…
- Wrap: `rr_ptr` = 3 with `req` = 4'b1001 → core 3 granted, then core 0, then core 3.
- Cancel in response cycle: grant core 2 at t, `cancel[2]`=1 at t+1 → `rsp_valid` = 0 at t+1; core 2 is eligible at t+2 with its new address.
- Cancel in issue cycle: `req` = 4'b0110, `cancel[1]`=1, `rr_ptr`=1 → core 2 granted, core 1 not.
- Reset mid-flight: grant core 1 at t, `rst`=1 at t+1 → no `rsp_valid` at t+1 or t+2; `rr_ptr` = 0 afterwards; the first grant after reset goes to the lowest requesting core.
